// File: rtl/ex_dispatch_pkg.sv
// Shared definitions for the step-counter dispatch block: function codes,
// FSM states, weight register indices and data widths.
package ex_dispatch_pkg;

    localparam int DATA_W      = 10;
    localparam int FUNCT_W     = 3;
    localparam int IDX_W       = 3;
    localparam int CMD_W       = 20;
    localparam int NUM_WEIGHTS = 6;

    localparam logic [FUNCT_W-1:0] FN_RESET  = 3'd0;
    localparam logic [FUNCT_W-1:0] FN_COUNT  = 3'd1;
    localparam logic [FUNCT_W-1:0] FN_UPDATE = 3'd2;

    localparam logic [IDX_W-1:0] IDX_THETA1_1 = 3'd0;
    localparam logic [IDX_W-1:0] IDX_THETA1_2 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_THETA2_1 = 3'd2;
    localparam logic [IDX_W-1:0] IDX_THETA2_2 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_ALPHA1   = 3'd4;
    localparam logic [IDX_W-1:0] IDX_ALPHA2   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_e;

    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return (idx <= IDX_ALPHA2);
    endfunction

endpackage

// File: rtl/ex_dispatch_if.sv
// Command and execute-block signal bundle for ex_dispatch; slave is the
// dispatcher side, master is the command source / execute-block side.
interface ex_dispatch_if #(parameter int CNT_W = 16);
    import ex_dispatch_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [FUNCT_W-1:0]   cmd_funct;
    logic [CMD_W-1:0]     cmd_data;
    logic [DATA_W-1:0]    ex_A;
    logic [DATA_W-1:0]    ex_B;
    logic [FUNCT_W-1:0]   ex_funct;
    logic [DATA_W-1:0]    ex_theta1_1;
    logic [DATA_W-1:0]    ex_theta1_2;
    logic [DATA_W-1:0]    ex_theta2_1;
    logic [DATA_W-1:0]    ex_theta2_2;
    logic [DATA_W-1:0]    ex_alpha1;
    logic [DATA_W-1:0]    ex_alpha2;
    logic                 ex_valid;
    logic                 ex_step;
    logic [CNT_W-1:0]     step_count;
    logic                 err;

    modport slave (
        input  cmd_valid, cmd_funct, cmd_data, ex_step,
        output cmd_ready, ex_A, ex_B, ex_funct,
               ex_theta1_1, ex_theta1_2, ex_theta2_1, ex_theta2_2, ex_alpha1, ex_alpha2,
               ex_valid, step_count, err
    );

    modport master (
        output cmd_valid, cmd_funct, cmd_data, ex_step,
        input  cmd_ready, ex_A, ex_B, ex_funct,
               ex_theta1_1, ex_theta1_2, ex_theta2_1, ex_theta2_2, ex_alpha1, ex_alpha2,
               ex_valid, step_count, err
    );

endinterface

// File: rtl/ex_weight_regs.sv
// Six 10-bit classifier weight registers with an indexed write port;
// out-of-range indices are dropped and flagged on wr_err.
module ex_weight_regs
    import ex_dispatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] theta1_1,
    output logic [DATA_W-1:0] theta1_2,
    output logic [DATA_W-1:0] theta2_1,
    output logic [DATA_W-1:0] theta2_2,
    output logic [DATA_W-1:0] alpha1,
    output logic [DATA_W-1:0] alpha2,
    output logic              wr_err
);

    logic [DATA_W-1:0] theta1_1_r;
    logic [DATA_W-1:0] theta1_2_r;
    logic [DATA_W-1:0] theta2_1_r;
    logic [DATA_W-1:0] theta2_2_r;
    logic [DATA_W-1:0] alpha1_r;
    logic [DATA_W-1:0] alpha2_r;

    // Indexed weight write; reset clears every weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta1_1_r <= 10'd0;
            theta1_2_r <= 10'd0;
            theta2_1_r <= 10'd0;
            theta2_2_r <= 10'd0;
            alpha1_r   <= 10'd0;
            alpha2_r   <= 10'd0;
        end else if (wr_en) begin
            case (wr_idx)
                IDX_THETA1_1: theta1_1_r <= wr_data;
                IDX_THETA1_2: theta1_2_r <= wr_data;
                IDX_THETA2_1: theta2_1_r <= wr_data;
                IDX_THETA2_2: theta2_2_r <= wr_data;
                IDX_ALPHA1:   alpha1_r   <= wr_data;
                IDX_ALPHA2:   alpha2_r   <= wr_data;
                default: begin
                end
            endcase
        end
    end

    assign wr_err   = wr_en && !idx_valid(wr_idx);
    assign theta1_1 = theta1_1_r;
    assign theta1_2 = theta1_2_r;
    assign theta2_1 = theta2_1_r;
    assign theta2_2 = theta2_2_r;
    assign alpha1   = alpha1_r;
    assign alpha2   = alpha2_r;

endmodule

// File: rtl/ex_dispatch.sv
// Command dispatcher for the step classifier: issues count samples to the
// execute block, retires edge-detected results into a saturating counter.
module ex_dispatch
    import ex_dispatch_pkg::*;
#(
    parameter int EX_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_dispatch_if.slave bus
);

    localparam int                WAIT_W    = (EX_LAT > 1) ? $clog2(EX_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((EX_LAT > 1) ? (EX_LAT - 2) : 0);
    localparam logic              HAS_WAIT  = (EX_LAT > 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e               state_r;
    state_e               state_next_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [WAIT_W-1:0]    wait_cnt_next_s;
    logic [DATA_W-1:0]    ex_a_r;
    logic [DATA_W-1:0]    ex_b_r;
    logic [FUNCT_W-1:0]   ex_funct_r;
    logic                 ex_valid_r;
    logic                 cmd_ready_r;
    logic [CNT_W-1:0]     step_count_r;
    logic                 prev_step_r;
    logic                 err_r;
    logic                 accept_s;
    logic                 wr_en_s;
    logic                 wr_err_s;
    logic                 cmd_data_unused_s;

    assign accept_s          = bus.cmd_valid && (state_r == ST_IDLE);
    assign wr_en_s           = accept_s && (bus.cmd_funct == FN_UPDATE);
    assign cmd_data_unused_s = ^bus.cmd_data[CMD_W-1:13];

    // Next-state logic; only a count command leaves IDLE.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (bus.cmd_funct == FN_COUNT)) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_next_s = {WAIT_W{1'b0}};
                if (HAS_WAIT) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_RETIRE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = ST_RETIRE;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_RETIRE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake strobes, command datapath and result retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            ex_a_r       <= 10'd0;
            ex_b_r       <= 10'd0;
            ex_funct_r   <= FN_RESET;
            ex_valid_r   <= 1'b0;
            cmd_ready_r  <= 1'b1;
            step_count_r <= {CNT_W{1'b0}};
            prev_step_r  <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            ex_valid_r  <= (state_next_s == ST_ISSUE);
            cmd_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                case (bus.cmd_funct)
                    FN_RESET: begin
                        step_count_r <= {CNT_W{1'b0}};
                        prev_step_r  <= 1'b0;
                        ex_funct_r   <= FN_RESET;
                    end
                    FN_COUNT: begin
                        ex_a_r     <= bus.cmd_data[9:0];
                        ex_b_r     <= bus.cmd_data[19:10];
                        ex_funct_r <= FN_COUNT;
                    end
                    FN_UPDATE: begin
                        if (wr_err_s) begin
                            err_r <= 1'b1;
                        end else begin
                            ex_funct_r <= FN_UPDATE;
                        end
                    end
                    default: begin
                        err_r <= 1'b1;
                    end
                endcase
            end else if (state_r == ST_RETIRE) begin
                // Count only rising edges of the classifier output, saturating.
                if (bus.ex_step && !prev_step_r && (step_count_r != CNT_MAX)) begin
                    step_count_r <= step_count_r + CNT_W'(1);
                end
                prev_step_r <= bus.ex_step;
            end
        end
    end

    ex_weight_regs u_weight_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .wr_idx   (bus.cmd_data[12:10]),
        .wr_data  (bus.cmd_data[9:0]),
        .theta1_1 (bus.ex_theta1_1),
        .theta1_2 (bus.ex_theta1_2),
        .theta2_1 (bus.ex_theta2_1),
        .theta2_2 (bus.ex_theta2_2),
        .alpha1   (bus.ex_alpha1),
        .alpha2   (bus.ex_alpha2),
        .wr_err   (wr_err_s)
    );

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.ex_A       = ex_a_r;
    assign bus.ex_B       = ex_b_r;
    assign bus.ex_funct   = ex_funct_r;
    assign bus.ex_valid   = ex_valid_r;
    assign bus.step_count = step_count_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_ex_dispatch.sv
// Directed bench for ex_dispatch: instance A (EX_LAT=1, CNT_W=16) and
// instance B (EX_LAT=3, CNT_W=4) with hand-computed expectations.
module tb_ex_dispatch;
    import ex_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ex_dispatch_if #(.CNT_W(16)) bus_a ();
    ex_dispatch_if #(.CNT_W(4))  bus_b ();

    ex_dispatch #(.EX_LAT(1), .CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave));
    ex_dispatch #(.EX_LAT(3), .CNT_W(4))  u_dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmd_a(input logic [2:0] f, input logic [19:0] d);
        @(negedge clk);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_funct = f;
        bus_a.cmd_data  = d;
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
    endtask

    task automatic cmd_b(input logic [2:0] f, input logic [19:0] d);
        @(negedge clk);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_funct = f;
        bus_b.cmd_data  = d;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
    endtask

    // Issue one count command and wait (bounded) for cmd_ready to return.
    task automatic count_a(input logic [9:0] a, input logic [9:0] b, input logic step,
                           output int lat, output int pulses, output int first);
        @(negedge clk);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_funct = FN_COUNT;
        bus_a.cmd_data  = {b, a};
        bus_a.ex_step   = step;
        lat = 0; pulses = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus_a.cmd_valid = 1'b0;
            if (bus_a.ex_valid) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (bus_a.cmd_ready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_val("count_a_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_b(input logic step, output int lat);
        @(negedge clk);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_funct = FN_COUNT;
        bus_b.cmd_data  = {10'd2, 10'd1};
        bus_b.ex_step   = step;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus_b.cmd_valid = 1'b0;
            if (bus_b.cmd_ready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_val("count_b_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, pulses, first;
        logic [2:0] seq_step [4];
        logic [31:0] seq_exp [4];
        seq_step = '{3'd1, 3'd1, 3'd0, 3'd1};
        seq_exp  = '{32'd1, 32'd1, 32'd1, 32'd2};

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_funct = 3'd0; bus_a.cmd_data = 20'd0; bus_a.ex_step = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_funct = 3'd0; bus_b.cmd_data = 20'd0; bus_b.ex_step = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_val("rst_ready",    32'(bus_a.cmd_ready), 32'd1);
        check_val("rst_valid",    32'(bus_a.ex_valid), 32'd0);
        check_val("rst_count",    32'(bus_a.step_count), 32'd0);
        check_val("rst_err",      32'(bus_a.err), 32'd0);
        check_val("rst_theta11",  32'(bus_a.ex_theta1_1), 32'd0);
        check_val("rst_alpha2",   32'(bus_a.ex_alpha2), 32'd0);
        check_val("rst_exA",      32'(bus_a.ex_A), 32'd0);
        check_val("rst_exfunct",  32'(bus_a.ex_funct), 32'd0);

        // Weight updates idx 0..5 <- 1..6, first one on the first edge after release
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_a.cmd_valid = 1'b1;
            bus_a.cmd_funct = FN_UPDATE;
            bus_a.cmd_data  = {7'd0, 3'(i), 10'(i + 1)};
            @(negedge clk);
            check_val("upd_ready", 32'(bus_a.cmd_ready), 32'd1);
        end
        bus_a.cmd_valid = 1'b0;
        check_val("upd_theta11", 32'(bus_a.ex_theta1_1), 32'd1);
        check_val("upd_theta12", 32'(bus_a.ex_theta1_2), 32'd2);
        check_val("upd_theta21", 32'(bus_a.ex_theta2_1), 32'd3);
        check_val("upd_theta22", 32'(bus_a.ex_theta2_2), 32'd4);
        check_val("upd_alpha1",  32'(bus_a.ex_alpha1), 32'd5);
        check_val("upd_alpha2",  32'(bus_a.ex_alpha2), 32'd6);
        check_val("upd_err",     32'(bus_a.err), 32'd0);
        check_val("upd_funct",   32'(bus_a.ex_funct), 32'd2);

        // Single count A=5 B=9, step=1
        count_a(10'd5, 10'd9, 1'b1, lat, pulses, first);
        check_val("cnt_latency", 32'(lat), 32'd3);
        check_val("cnt_pulses",  32'(pulses), 32'd1);
        check_val("cnt_first",   32'(first), 32'd1);
        check_val("cnt_count",   32'(bus_a.step_count), 32'd1);
        check_val("cnt_exA",     32'(bus_a.ex_A), 32'd5);
        check_val("cnt_exB",     32'(bus_a.ex_B), 32'd9);
        check_val("cnt_funct",   32'(bus_a.ex_funct), 32'd1);

        // Counter clear, then edge detection over 1,1,0,1
        cmd_a(FN_RESET, 20'd0);
        check_val("clr_count", 32'(bus_a.step_count), 32'd0);
        check_val("clr_funct", 32'(bus_a.ex_funct), 32'd0);
        for (int i = 0; i < 4; i++) begin
            count_a(10'd1, 10'd2, seq_step[i][0], lat, pulses, first);
            check_val("edge_count", 32'(bus_a.step_count), seq_exp[i]);
        end

        // ex_step toggling while idle must not touch prev_step or the count
        bus_a.ex_step = 1'b0;
        repeat (3) @(negedge clk);
        bus_a.ex_step = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_count", 32'(bus_a.step_count), 32'd2);
        count_a(10'd1, 10'd2, 1'b1, lat, pulses, first);
        check_val("idle_prev", 32'(bus_a.step_count), 32'd2);

        // Illegal commands
        cmd_a(FN_UPDATE, {7'd0, 3'd6, 10'h3FF});
        check_val("ill_idx_err",    32'(bus_a.err), 32'd1);
        check_val("ill_idx_th11",   32'(bus_a.ex_theta1_1), 32'd1);
        check_val("ill_idx_alpha2", 32'(bus_a.ex_alpha2), 32'd6);
        check_val("ill_idx_funct",  32'(bus_a.ex_funct), 32'd1);
        cmd_a(3'd5, 20'hFFFFF);
        check_val("ill_fn_err",    32'(bus_a.err), 32'd1);
        check_val("ill_fn_th22",   32'(bus_a.ex_theta2_2), 32'd4);
        check_val("ill_fn_ready",  32'(bus_a.cmd_ready), 32'd1);
        cmd_a(FN_RESET, 20'd0);
        check_val("ill_clr_count", 32'(bus_a.step_count), 32'd0);
        check_val("ill_clr_err",   32'(bus_a.err), 32'd1);
        check_val("ill_clr_th21",  32'(bus_a.ex_theta2_1), 32'd3);

        // Instance B: saturation at 15 over 40 alternating samples, EX_LAT=3 timing
        for (int i = 0; i < 40; i++) begin
            count_b((i % 2) == 0, lat);
            if (i == 0) check_val("b_latency", 32'(lat), 32'd5);
            if (i == 19) check_val("b_count_mid", 32'(bus_b.step_count), 32'd10);
        end
        check_val("b_count_sat", 32'(bus_b.step_count), 32'd15);

        // Instance B: reset in WAIT abandons the sample
        cmd_b(FN_UPDATE, {7'd0, 3'd0, 10'd7});
        cmd_b(3'd6, 20'd0);
        check_val("b_pre_err",  32'(bus_b.err), 32'd1);
        check_val("b_pre_th11", 32'(bus_b.ex_theta1_1), 32'd7);
        @(negedge clk);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_funct = FN_COUNT;
        bus_b.cmd_data  = {10'd4, 10'd5};
        bus_b.ex_step   = 1'b1;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        check_val("b_issue_valid", 32'(bus_b.ex_valid), 32'd1);
        @(negedge clk);
        check_val("b_wait_ready", 32'(bus_b.cmd_ready), 32'd0);
        #1 rst_n_b = 1'b0;
        #1;
        check_val("b_rst_ready", 32'(bus_b.cmd_ready), 32'd1);
        check_val("b_rst_valid", 32'(bus_b.ex_valid), 32'd0);
        check_val("b_rst_count", 32'(bus_b.step_count), 32'd0);
        check_val("b_rst_err",   32'(bus_b.err), 32'd0);
        check_val("b_rst_th11",  32'(bus_b.ex_theta1_1), 32'd0);
        check_val("b_rst_exA",   32'(bus_b.ex_A), 32'd0);
        check_val("b_rst_funct", 32'(bus_b.ex_funct), 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1;
        repeat (8) @(negedge clk);
        check_val("b_post_count", 32'(bus_b.step_count), 32'd0);
        check_val("b_post_ready", 32'(bus_b.cmd_ready), 32'd1);
        check_val("b_post_valid", 32'(bus_b.ex_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
